fifo_stream_reader: RTL and testbench

Drain side for the team's synchronous FIFO in standard (non-FWFT) read mode. Issues FIFO reads against the `empty` flag, absorbs the one-cycle read latency in a 2-entry skid buffer, and presents the words on a valid/ready stream master at full throughput. Optionally frames the stream into fixed-length packets with `m_tlast`. Sits between any `syncfifo` instance and a downstream stream consumer, such as a UART TX or DMA write port.

---
 rtl/periph_stream_pkg.sv | 13 +
 rtl/fifo_rd_skid.sv | 46 ++++
 rtl/fifo_stream_reader.sv | 74 +++++++
 tb/tb_fifo_stream_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_stream_pkg.sv
// Shared types and helpers for the stream-side peripherals.
package periph_stream_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer that absorbs the FIFO read latency and feeds the stream head.
module fifo_rd_skid #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output periph_stream_pkg::occ_t occ
);
    import periph_stream_pkg::*;

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic                  head;
    logic                  tail;

    assign valid     = (occ != '0);
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            head <= 1'b0;
            tail <= 1'b0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            occ <= occ_t'(occ + occ_t'(push) - occ_t'(pop));
        end
    end

    occ_bound_a: assert property (@(posedge clk) disable iff (rst) occ <= occ_t'(SKID_DEPTH));
    pop_valid_a: assert property (@(posedge clk) disable iff (rst) pop |-> valid);

endmodule

// File: rtl/fifo_stream_reader.sv
// Non-FWFT FIFO drain into a valid/ready stream master at full rate.
// Define FIFO_RD_TLAST_EN to frame the stream into PKT_LEN-beat packets with m_tlast.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PKT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
);
    import periph_stream_pkg::*;

    logic       inflight;
    logic       pop;
    occ_t       occ;
    logic [2:0] level;

    assign pop = m_tvalid & m_tready;

    // Combinational from m_tready so a pop frees a slot in the same cycle.
    always_comb begin
        level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        fifo_rd_en = !rst && !fifo_empty && (level < 3'(SKID_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(fifo_dout),
        .pop      (pop),
        .valid    (m_tvalid),
        .head_data(m_tdata),
        .occ      (occ)
    );

`ifdef FIFO_RD_TLAST_EN
    localparam int unsigned        CW   = clog2_min1(PKT_LEN);
    localparam logic [CW-1:0]      LAST = CW'(PKT_LEN - 1);

    logic [CW-1:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
        end
    end

    assign m_tlast = m_tvalid & (beat_cnt == LAST);
`else
    assign m_tlast = 1'b0;
`endif

    pkt_len_a: assert property (@(posedge clk) PKT_LEN >= 2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a queue-based stream model and a behavioural FIFO.
module tb_fifo_stream_reader;

    localparam int unsigned DW  = 32;
    localparam int unsigned PKT = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .PKT_LEN   (PKT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast)
    );

    // Behavioural synchronous FIFO, standard read mode.
    logic [DW-1:0] mem [256];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= 0;
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: words leave in write order; tlast every PKT-th beat since reset.
    logic [DW-1:0] exp_q[$];
    int            outstanding = 0;
    int            pkt_cnt = 0;
    int            cyc = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            first_rd = -1;
    int            first_vld = -1;
    int            beat_n = 0;
    logic [DW-1:0] beat_data [64];
    logic          beat_last [64];
    int            beat_cyc  [64];
    logic          rand_mode = 1'b0;

    always @(negedge clk) begin
        logic exp_last;
        cyc++;
        if (rst) begin
            chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            exp_q.delete();
            outstanding = 0;
            pkt_cnt     = 0;
            prev_stall  = 1'b0;
        end else begin
            chk("rd_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
`ifdef FIFO_RD_TLAST_EN
            exp_last = (pkt_cnt == PKT - 1);
`else
            exp_last = 1'b0;
`endif
            if (prev_stall) begin
                chk("hold_valid", {31'd0, m_tvalid}, 32'd1);
                chk("hold_data", m_tdata, prev_data);
            end
            if (m_tvalid) begin
                if (first_vld < 0) first_vld = cyc;
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {31'd0, m_tvalid}, 32'd0);
                end else begin
                    chk("tdata", m_tdata, exp_q[0]);
                end
                chk("tlast", {31'd0, m_tlast}, {31'd0, exp_last});
            end else begin
                chk("tlast_idle", {31'd0, m_tlast}, 32'd0);
            end
            if (m_tvalid && m_tready) begin
                if (beat_n < 64) begin
                    beat_data[beat_n] = m_tdata;
                    beat_last[beat_n] = m_tlast;
                    beat_cyc[beat_n]  = cyc;
                end
                beat_n++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                outstanding--;
                pkt_cnt = (pkt_cnt + 1) % PKT;
            end
            if (fifo_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                outstanding++;
            end
            checks++;
            if (outstanding > 2) begin
                errors++;
                $display("FAIL occ_bound: got %0d expected <=2 at %0t", outstanding, $time);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic fifo_write(input logic [DW-1:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr++;
        exp_q.push_back(w);
    endtask

    task automatic mark();
        first_rd  = -1;
        first_vld = -1;
        beat_n    = 0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beat_n < n && k < budget) begin
            tick();
            k++;
        end
        chk("beat_budget", {31'd0, beat_n >= n}, 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        wr_ptr = 0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        m_tready = 1'b0;
        tick();
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_rd_en_init", {31'd0, fifo_rd_en}, 32'd0);
        do_reset(2);

        // Idle FIFO: nothing moves.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            chk("idle_valid", {31'd0, m_tvalid}, 32'd0);
        end

        // Full-rate burst of 0x1..0x8.
        m_tready = 1'b1;
        mark();
        for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
        wait_beats(8, 50);
        chk("latency", DW'(first_vld - first_rd), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("burst_data", beat_data[i], DW'(i + 1));
            chk("burst_rate", DW'(beat_cyc[i] - beat_cyc[0]), DW'(i));
        end

        // Random backpressure.
        mark();
        rand_mode = 1'b1;
        for (int i = 0; i < 8; i++) fifo_write(DW'(32'h11 + i));
        wait_beats(8, 300);
        rand_mode = 1'b0;
        m_tready  = 1'b1;
        for (int i = 0; i < 8; i++) chk("bp_data", beat_data[i], DW'(32'h11 + i));

`ifdef FIFO_RD_TLAST_EN
        // Framing: 10 beats, a FIFO gap, then 2 more beats.
        do_reset(1);
        mark();
        for (int i = 0; i < 10; i++) fifo_write(DW'(32'h21 + i));
        wait_beats(10, 50);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("gap_valid", {31'd0, m_tvalid}, 32'd0);
        end
        fifo_write(32'h2B);
        fifo_write(32'h2C);
        wait_beats(12, 50);
        for (int i = 0; i < 12; i++) begin
            chk("frame_data", beat_data[i], DW'(32'h21 + i));
            chk("frame_last", {31'd0, beat_last[i]}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
        end
`else
        mark();
        for (int i = 0; i < 40; i++) fifo_write(DW'(32'h100 + i));
        wait_beats(40, 100);
        for (int i = 0; i < 40; i++) begin
            chk("nofrm_data", beat_data[i], DW'(32'h100 + i));
            chk("nofrm_last", {31'd0, beat_last[i]}, 32'd0);
        end
`endif

        // Reset while the skid buffer is full.
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(DW'(32'h31 + i));
        repeat (5) tick();
        chk("full_valid", {31'd0, m_tvalid}, 32'd1);
        chk("full_head", m_tdata, 32'h31);
        m_tready = 1'b1;
        do_reset(1);
        chk("post_rst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("post_rst_tlast", {31'd0, m_tlast}, 32'd0);
        mark();
        fifo_write(32'h41);
        fifo_write(32'h42);
        wait_beats(2, 50);
        chk("refill_first", beat_data[0], 32'h41);
        chk("refill_second", beat_data[1], 32'h42);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
